// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Contents:
//   state_e        FSM state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  default operand/result width
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: a - b - bin.
// Ports:
//   a_i, b_i  minuend / subtrahend bits
//   bin_i     incoming borrow
//   diff_o    difference bit
//   bout_o    outgoing borrow
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  assign diff_o = a_i ^ b_i ^ bin_i;
  // Borrow out when a<b outright, or when a==b and a borrow is already pending.
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first,
// using a single full-subtractor cell and a registered borrow.
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   start        request, accepted when not busy (IDLE or DONE)
//   a, b         operands, captured on the accept edge
//   diff         (a - b) mod 2^WIDTH, held until the next RUN phase ends
//   borrow_out   1 iff a < b, held like diff
//   busy         high while the FSM is in RUN
//   done         one-cycle pulse when the result is valid
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             state_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   diff_sh_q;
  logic [WIDTH-1:0]   diff_sh_d;
  logic               borrow_q;
  logic               borrow_d;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   diff_q;
  logic               borrow_out_q;
  logic               busy_q;
  logic               done_q;

  logic               d_c;
  logic               accept_c;
  logic               last_c;

  // Single shared bit-step cell on the current LSBs and pending borrow.
  full_subtractor u_fs (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .bin_i  (borrow_q),
    .diff_o (d_c),
    .bout_o (borrow_d)
  );

  assign diff_sh_d = {d_c, diff_sh_q[WIDTH-1:1]};
  assign accept_c  = start && (state_q != RUN);
  assign last_c    = (count_q == CNT_W'(WIDTH - 1));

  // FSM, operand/result shifters, borrow and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      diff_sh_q    <= '0;
      borrow_q     <= 1'b0;
      count_q      <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept_c) begin
        // Result registers are left alone so a back-to-back accept keeps them valid.
        a_sh_q    <= a;
        b_sh_q    <= b;
        diff_sh_q <= '0;
        borrow_q  <= 1'b0;
        count_q   <= '0;
        state_q   <= RUN;
        busy_q    <= 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            a_sh_q    <= {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_q    <= {1'b0, b_sh_q[WIDTH-1:1]};
            diff_sh_q <= diff_sh_d;
            borrow_q  <= borrow_d;
            if (last_c) begin
              state_q      <= DONE;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              diff_q       <= diff_sh_d;
              borrow_out_q <= borrow_d;
            end else begin
              // Held at WIDTH-1 on the final bit so the counter never wraps.
              count_q <= count_q + CNT_W'(1);
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         busy;
  logic         done;

  int n_cmp;
  int n_mis;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .diff       (diff),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge; returns at the negedge after the accept edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // From the negedge after an accept, wait (bounded) for done; report cycles and busy cycles.
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = busy ? 1 : 0;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cycles++;
    end
  endtask

  logic [W-1:0] va [3];
  logic [W-1:0] vb [3];
  logic [W-1:0] vd [3];
  logic         vbo[3];

  initial begin
    int cyc, bcyc, pulses;
    logic [W-1:0] cap_diff;
    logic [W-1:0] ra, rb;

    n_cmp = 0;
    n_mis = 0;
    start = 1'b0;
    a     = '0;
    b     = '0;

    va[0] = 8'd3;   vb[0] = 8'd5;   vd[0] = 8'hFE; vbo[0] = 1'b1;
    va[1] = 8'h00;  vb[1] = 8'hFF;  vd[1] = 8'h01; vbo[1] = 1'b1;
    va[2] = 8'hA5;  vb[2] = 8'hA5;  vd[2] = 8'h00; vbo[2] = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_diff", 32'(diff), 32'd0);
    check_eq("rst_borrow", 32'(borrow_out), 32'd0);
    rst = 1'b0;

    // 1: 5 - 3
    start_op(8'd5, 8'd3);
    wait_done(cyc, bcyc);
    check_eq("t1_latency", 32'(cyc), 32'd8);
    check_eq("t1_busy_cycles", 32'(bcyc), 32'd8);
    check_eq("t1_diff", 32'(diff), 32'h02);
    check_eq("t1_borrow", 32'(borrow_out), 32'd0);
    check_eq("t1_busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("t1_done_pulse", 32'(done), 32'd0);
    check_eq("t1_diff_held", 32'(diff), 32'h02);

    // 2: boundary vectors
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i]);
      wait_done(cyc, bcyc);
      check_eq($sformatf("t2_latency_%0d", i), 32'(cyc), 32'd8);
      check_eq($sformatf("t2_diff_%0d", i), 32'(diff), 32'(vd[i]));
      check_eq($sformatf("t2_borrow_%0d", i), 32'(borrow_out), 32'(vbo[i]));
    end

    // 3: start while busy is ignored
    start_op(8'd7, 8'd2);
    pulses   = 0;
    cap_diff = '1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        pulses++;
        cap_diff = diff;
      end
      if (i == 2) begin
        a     = 8'd9;
        b     = 8'd1;
        start = 1'b1;
      end
      if (i == 3) start = 1'b0;
      @(negedge clk);
    end
    check_eq("t3_pulses", 32'(pulses), 32'd1);
    check_eq("t3_diff", 32'(cap_diff), 32'd5);
    check_eq("t3_idle", 32'(busy), 32'd0);

    // 4: back-to-back with start held through DONE
    start_op(8'd50, 8'd20);
    repeat (7) @(negedge clk);
    a     = 8'd200;
    b     = 8'd100;
    start = 1'b1;
    @(negedge clk);
    check_eq("t4_done1", 32'(done), 32'd1);
    check_eq("t4_diff1", 32'(diff), 32'd30);
    @(negedge clk);
    start = 1'b0;
    check_eq("t4_reaccept_busy", 32'(busy), 32'd1);
    check_eq("t4_reaccept_done", 32'(done), 32'd0);
    check_eq("t4_diff1_held", 32'(diff), 32'd30);
    wait_done(cyc, bcyc);
    check_eq("t4_latency2", 32'(cyc), 32'd8);
    check_eq("t4_diff2", 32'(diff), 32'd100);
    check_eq("t4_borrow2", 32'(borrow_out), 32'd0);

    // 5: async reset mid-run
    start_op(8'h11, 8'h22);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_done", 32'(done), 32'd0);
    check_eq("t5_diff", 32'(diff), 32'd0);
    check_eq("t5_borrow", 32'(borrow_out), 32'd0);
    check_eq("t5_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_eq("t5_no_done", 32'(pulses), 32'd0);

    // 6: random sweep
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      start_op(ra, rb);
      a = W'($urandom);
      b = W'($urandom);
      wait_done(cyc, bcyc);
      check_eq($sformatf("t6_diff_%0h_%0h", ra, rb), 32'(diff), 32'(W'(ra - rb)));
      check_eq($sformatf("t6_borrow_%0h_%0h", ra, rb), 32'(borrow_out), 32'(ra < rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_serial_subtractor
